// File: rtl/fir_pkg.sv
// Shared defaults and FSM state encoding for the FIR coefficient sequencer.
package fir_pkg;

    localparam int unsigned COEFF_WIDTH_DEF = 8;
    localparam int unsigned NUM_TAPS_DEF    = 8;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_RUN  = 2'd1;
    localparam state_t ST_DONE = 2'd2;

endpackage

// File: rtl/coeff_bank_mem.sv
// One coefficient bank: synchronous write, asynchronous read, reset loads
// the descending default table (entry i = NUM_TAPS - i).
module coeff_bank_mem
    import fir_pkg::*;
#(
    parameter int unsigned COEFF_WIDTH = COEFF_WIDTH_DEF,
    parameter int unsigned NUM_TAPS    = NUM_TAPS_DEF,
    parameter int unsigned ADDR_WIDTH  = $clog2(NUM_TAPS)
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   we,
    input  logic [ADDR_WIDTH-1:0]  waddr,
    input  logic [COEFF_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0]  raddr,
    output logic [COEFF_WIDTH-1:0] rdata
);

    logic [COEFF_WIDTH-1:0] mem [NUM_TAPS];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(NUM_TAPS); i++) begin
                mem[i] <= COEFF_WIDTH'(int'(NUM_TAPS) - i);
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/coeff_sequencer.sv
// Double-banked coefficient sequencer: streams one bank forward or reversed
// while the other bank is rewritten, with deferred bank swap during a run.
module coeff_sequencer
    import fir_pkg::*;
#(
    parameter int unsigned COEFF_WIDTH = COEFF_WIDTH_DEF,
    parameter int unsigned NUM_TAPS    = NUM_TAPS_DEF,
    parameter int unsigned ADDR_WIDTH  = $clog2(NUM_TAPS)
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   en,
    input  logic                   start,
    input  logic                   reverse,
    input  logic                   wr_en,
    input  logic [ADDR_WIDTH-1:0]  wr_addr,
    input  logic [COEFF_WIDTH-1:0] wr_data,
    input  logic                   swap_req,
    output logic [COEFF_WIDTH-1:0] coeff_out,
    output logic                   coeff_valid,
    output logic                   coeff_last,
    output logic [ADDR_WIDTH-1:0]  coeff_addr,
    output logic                   busy,
    output logic                   done,
    output logic                   active_bank,
    output logic                   swap_pending
);

    localparam logic [ADDR_WIDTH-1:0] LAST_IDX  = ADDR_WIDTH'(NUM_TAPS - 1);
    localparam logic [ADDR_WIDTH:0]   TAP_LIMIT = (ADDR_WIDTH + 1)'(NUM_TAPS);

    state_t                 state, state_nxt;
    logic [ADDR_WIDTH-1:0]  idx, idx_nxt;
    logic                   rev, rev_nxt;
    logic                   bank_nxt, pend_nxt;
    logic [COEFF_WIDTH-1:0] out_nxt;
    logic                   valid_nxt, last_nxt, busy_nxt, done_nxt;
    logic [ADDR_WIDTH-1:0]  addr_nxt;
    logic [ADDR_WIDTH-1:0]  end_idx;

    logic                   wr_ok, we0, we1;
    logic [COEFF_WIDTH-1:0] rd_data0, rd_data1, rd_data;

    // Writes use the pre-edge bank select, so a write coinciding with a swap
    // lands in the bank that is about to become active.
    assign wr_ok = wr_en && ({1'b0, wr_addr} < TAP_LIMIT);
    assign we0   = wr_ok && active_bank;
    assign we1   = wr_ok && !active_bank;

    coeff_bank_mem #(
        .COEFF_WIDTH (COEFF_WIDTH),
        .NUM_TAPS    (NUM_TAPS),
        .ADDR_WIDTH  (ADDR_WIDTH)
    ) u_bank0 (
        .clock (clock),
        .reset (reset),
        .we    (we0),
        .waddr (wr_addr),
        .wdata (wr_data),
        .raddr (idx),
        .rdata (rd_data0)
    );

    coeff_bank_mem #(
        .COEFF_WIDTH (COEFF_WIDTH),
        .NUM_TAPS    (NUM_TAPS),
        .ADDR_WIDTH  (ADDR_WIDTH)
    ) u_bank1 (
        .clock (clock),
        .reset (reset),
        .we    (we1),
        .waddr (wr_addr),
        .wdata (wr_data),
        .raddr (idx),
        .rdata (rd_data1)
    );

    assign rd_data = active_bank ? rd_data1 : rd_data0;
    assign end_idx = rev ? '0 : LAST_IDX;

    // Next state and next registered outputs.
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        rev_nxt   = rev;
        bank_nxt  = active_bank;
        pend_nxt  = swap_pending;
        out_nxt   = '0;
        valid_nxt = 1'b0;
        last_nxt  = 1'b0;
        addr_nxt  = '0;

        case (state)
            ST_IDLE: begin
                if (swap_req || swap_pending) begin
                    bank_nxt = ~active_bank;
                    pend_nxt = 1'b0;
                end
                if (start && en) begin
                    state_nxt = ST_RUN;
                    rev_nxt   = reverse;
                    idx_nxt   = reverse ? LAST_IDX : '0;
                end
            end
            ST_RUN: begin
                if (swap_req) begin
                    pend_nxt = 1'b1;
                end
                // The final coefficient is on the outputs; the next cycle is DONE.
                if (coeff_last) begin
                    state_nxt = ST_DONE;
                end else if (en) begin
                    out_nxt   = rd_data;
                    valid_nxt = 1'b1;
                    addr_nxt  = idx;
                    last_nxt  = (idx == end_idx);
                    idx_nxt   = rev ? (idx - ADDR_WIDTH'(1)) : (idx + ADDR_WIDTH'(1));
                end
            end
            ST_DONE: begin
                if (swap_req) begin
                    pend_nxt = 1'b1;
                end
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        busy_nxt = (state_nxt != ST_IDLE);
        done_nxt = (state_nxt == ST_DONE);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            idx          <= '0;
            rev          <= 1'b0;
            active_bank  <= 1'b0;
            swap_pending <= 1'b0;
            coeff_out    <= '0;
            coeff_valid  <= 1'b0;
            coeff_last   <= 1'b0;
            coeff_addr   <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            state        <= state_nxt;
            idx          <= idx_nxt;
            rev          <= rev_nxt;
            active_bank  <= bank_nxt;
            swap_pending <= pend_nxt;
            coeff_out    <= out_nxt;
            coeff_valid  <= valid_nxt;
            coeff_last   <= last_nxt;
            coeff_addr   <= addr_nxt;
            busy         <= busy_nxt;
            done         <= done_nxt;
        end
    end

endmodule

// File: tb/tb_coeff_sequencer.sv
// Directed bench for coeff_sequencer: default 8-tap instance plus a 9-tap
// instance exercising a non-power-of-two depth and out-of-range writes.
module tb_coeff_sequencer;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       en = 1'b0;
    logic       start = 1'b0;
    logic       reverse = 1'b0;
    logic       wr_en = 1'b0;
    logic [2:0] wr_addr = '0;
    logic [7:0] wr_data = '0;
    logic       swap_req = 1'b0;
    logic [7:0] coeff_out;
    logic       coeff_valid, coeff_last;
    logic [2:0] coeff_addr;
    logic       busy, done, active_bank, swap_pending;

    logic       start9 = 1'b0;
    logic       wr_en9 = 1'b0;
    logic [3:0] wr_addr9 = '0;
    logic [7:0] wr_data9 = '0;
    logic       swap9 = 1'b0;
    logic [7:0] out9;
    logic       valid9, last9;
    logic [3:0] addr9;
    logic       busy9, done9, bank9, pend9;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    coeff_sequencer u_dut (
        .clock        (clock),
        .reset        (reset),
        .en           (en),
        .start        (start),
        .reverse      (reverse),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .swap_req     (swap_req),
        .coeff_out    (coeff_out),
        .coeff_valid  (coeff_valid),
        .coeff_last   (coeff_last),
        .coeff_addr   (coeff_addr),
        .busy         (busy),
        .done         (done),
        .active_bank  (active_bank),
        .swap_pending (swap_pending)
    );

    coeff_sequencer #(.COEFF_WIDTH(8), .NUM_TAPS(9)) u_dut9 (
        .clock        (clock),
        .reset        (reset),
        .en           (en),
        .start        (start9),
        .reverse      (reverse),
        .wr_en        (wr_en9),
        .wr_addr      (wr_addr9),
        .wr_data      (wr_data9),
        .swap_req     (swap9),
        .coeff_out    (out9),
        .coeff_valid  (valid9),
        .coeff_last   (last9),
        .coeff_addr   (addr9),
        .busy         (busy9),
        .done         (done9),
        .active_bank  (bank9),
        .swap_pending (pend9)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        @(negedge clock);
    endtask

    // Advance one edge and expect a valid coefficient on the outputs.
    task automatic expect_coeff(input string tag, input logic [7:0] d, input logic [2:0] a,
                                input logic l);
        step();
        check({tag, " valid"}, 32'(coeff_valid), 32'd1);
        check({tag, " data"}, 32'(coeff_out), 32'(d));
        check({tag, " addr"}, 32'(coeff_addr), 32'(a));
        check({tag, " last"}, 32'(coeff_last), 32'(l));
    endtask

    task automatic expect_done(input string tag);
        step();
        check({tag, " done"}, 32'(done), 32'd1);
        check({tag, " busy_done"}, 32'(busy), 32'd1);
        check({tag, " valid_done"}, 32'(coeff_valid), 32'd0);
    endtask

    initial begin
        // Reset state
        #1 reset = 1'b1;
        #1;
        check("rst out", 32'(coeff_out), 32'd0);
        check("rst valid", 32'(coeff_valid), 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        check("rst done", 32'(done), 32'd0);
        check("rst bank", 32'(active_bank), 32'd0);
        check("rst pend", 32'(swap_pending), 32'd0);
        @(negedge clock);
        reset = 1'b0;

        // Forward run on default bank
        en = 1'b1; start = 1'b1; reverse = 1'b0;
        step();
        start = 1'b0;
        check("fwd busy", 32'(busy), 32'd1);
        check("fwd first_lat", 32'(coeff_valid), 32'd0);
        for (int k = 0; k < 8; k++) expect_coeff("fwd", 8'(8 - k), 3'(k), k == 7);
        expect_done("fwd");
        start = 1'b1;
        step();
        start = 1'b0;
        check("start_in_done busy", 32'(busy), 32'd0);
        check("done single", 32'(done), 32'd0);
        step();
        check("idle busy", 32'(busy), 32'd0);

        // Reverse run
        reverse = 1'b1; start = 1'b1;
        step();
        start = 1'b0; reverse = 1'b0;
        for (int k = 0; k < 8; k++) expect_coeff("rev", 8'(k + 1), 3'(7 - k), k == 7);
        expect_done("rev");
        step();

        // Load shadow bank; last write coincides with the swap
        wr_en = 1'b1;
        for (int a = 0; a < 8; a++) begin
            wr_addr = 3'(a);
            wr_data = 8'(8'h10 + a);
            swap_req = (a == 7);
            step();
        end
        wr_en = 1'b0; swap_req = 1'b0;
        check("swap bank", 32'(active_bank), 32'd1);
        check("swap pend", 32'(swap_pending), 32'd0);
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 8; k++) expect_coeff("bank1", 8'(8'h10 + k), 3'(k), k == 7);
        expect_done("bank1");
        step();

        // Swap back, then request a swap on the third coefficient of a run
        swap_req = 1'b1;
        step();
        swap_req = 1'b0;
        check("swapback bank", 32'(active_bank), 32'd0);
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 8; k++) begin
            expect_coeff("midswap", 8'(8 - k), 3'(k), k == 7);
            swap_req = (k == 2);
            if (k >= 3) check("midswap pend", 32'(swap_pending), 32'd1);
        end
        expect_done("midswap");
        check("midswap bank_done", 32'(active_bank), 32'd0);
        check("midswap pend_done", 32'(swap_pending), 32'd1);
        step();
        check("midswap bank_idle0", 32'(active_bank), 32'd0);
        check("midswap pend_idle0", 32'(swap_pending), 32'd1);
        step();
        check("midswap bank_applied", 32'(active_bank), 32'd1);
        check("midswap pend_clear", 32'(swap_pending), 32'd0);

        // Start coinciding with swap, plus a two-cycle stall
        start = 1'b1; swap_req = 1'b1;
        step();
        start = 1'b0; swap_req = 1'b0;
        check("stall bank", 32'(active_bank), 32'd0);
        for (int k = 0; k < 4; k++) expect_coeff("stall_pre", 8'(8 - k), 3'(k), 1'b0);
        en = 1'b0;
        for (int k = 0; k < 2; k++) begin
            step();
            check("stall valid", 32'(coeff_valid), 32'd0);
            check("stall out", 32'(coeff_out), 32'd0);
            check("stall busy", 32'(busy), 32'd1);
        end
        en = 1'b1;
        for (int k = 4; k < 8; k++) expect_coeff("stall_post", 8'(8 - k), 3'(k), k == 7);
        expect_done("stall");
        step();

        // Reset in the middle of a run
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 5; k++) expect_coeff("mrst", 8'(8 - k), 3'(k), 1'b0);
        reset = 1'b1;
        #1;
        check("mrst out", 32'(coeff_out), 32'd0);
        check("mrst valid", 32'(coeff_valid), 32'd0);
        check("mrst addr", 32'(coeff_addr), 32'd0);
        check("mrst busy", 32'(busy), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        step();
        check("mrst no_done", 32'(done), 32'd0);
        check("mrst idle", 32'(busy), 32'd0);
        // Bank 1 held 0x10.. before reset; it must be back to defaults
        start = 1'b1; swap_req = 1'b1;
        step();
        start = 1'b0; swap_req = 1'b0;
        check("post_rst bank", 32'(active_bank), 32'd1);
        for (int k = 0; k < 8; k++) expect_coeff("post_rst", 8'(8 - k), 3'(k), k == 7);
        expect_done("post_rst");
        step();

        // Nine-tap instance: out-of-range write ignored, legal write lands
        wr_en9 = 1'b1; wr_addr9 = 4'd9; wr_data9 = 8'hAA;
        step();
        wr_addr9 = 4'd0; wr_data9 = 8'h33;
        step();
        wr_en9 = 1'b0; swap9 = 1'b1;
        step();
        swap9 = 1'b0;
        check("n9 bank", 32'(bank9), 32'd1);
        start9 = 1'b1;
        step();
        start9 = 1'b0;
        for (int k = 0; k < 9; k++) begin
            step();
            check("n9 valid", 32'(valid9), 32'd1);
            check("n9 data", 32'(out9), (k == 0) ? 32'h33 : 32'(9 - k));
            check("n9 addr", 32'(addr9), 32'(k));
            check("n9 last", 32'(last9), 32'(k == 8));
        end
        step();
        check("n9 done", 32'(done9), 32'd1);
        check("n9 busy", 32'(busy9), 32'd1);
        step();
        check("n9 idle", 32'(busy9), 32'd0);
        check("n9 pend", 32'(pend9), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/coeff_sequencer.md
COEFF_SEQUENCER -- requirements
Module: coeff_sequencer

Interface
REQ-001 SHALL have parameter COEFF_WIDTH, default 8, giving the coefficient bit width.
REQ-002 SHALL have parameter NUM_TAPS, default 8, giving the coefficients per bank; legal range is 2..256.
REQ-003 SHALL have derived parameter ADDR_WIDTH, default clog2(NUM_TAPS), giving the address width.
REQ-004 SHALL have port clock, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port en, input, 1 bit: global run enable; low stalls the sequencer.
REQ-007 SHALL have port start, input, 1 bit: begin a coefficient sequence.
REQ-008 SHALL have port reverse, input, 1 bit: order select, sampled with start; 0 gives index 0 to N-1, 1 gives N-1 to 0.
REQ-009 SHALL have ports wr_en (input, 1), wr_addr (input, ADDR_WIDTH) and wr_data (input, COEFF_WIDTH): the shadow-bank write port.
REQ-010 SHALL have port swap_req, input, 1 bit: request exchange of the active and shadow banks.
REQ-011 SHALL have port coeff_out, output, COEFF_WIDTH: registered coefficient.
REQ-012 SHALL have ports coeff_valid (output, 1), coeff_last (output, 1) and coeff_addr (output, ADDR_WIDTH): qualifiers for coeff_out.
REQ-013 SHALL have ports busy (output, 1), done (output, 1, single-cycle pulse), active_bank (output, 1) and swap_pending (output, 1).

Function
REQ-014 SHALL hold two banks of NUM_TAPS coefficients; reads use the active bank only, writes target the shadow bank only.
REQ-015 SHALL use FSM states IDLE, RUN and DONE: IDLE to RUN on start&en; RUN to DONE after the last coefficient is emitted; DONE to IDLE unconditionally after one cycle.
REQ-016 SHALL ignore start while in RUN or DONE.
REQ-017 SHALL present the first coefficient with coeff_valid=1 one cycle after the accepting start edge, then one per enabled cycle.
REQ-018 SHALL, in any RUN cycle with en=0, freeze the index and drive coeff_valid=0 and coeff_out=0, resuming with the next unemitted index when en returns high.
REQ-019 SHALL assert coeff_last together with the final valid coefficient, and assert done for exactly the following cycle (DONE state).
REQ-020 SHALL assert busy in RUN and DONE.
REQ-021 SHALL drive coeff_out, coeff_valid, coeff_last and coeff_addr to 0 whenever no valid coefficient is presented.
REQ-022 SHALL perform a write on wr_en at a rising edge in any state, independent of en; a wr_addr >= NUM_TAPS SHALL be ignored.
REQ-023 SHALL, when a write and a swap occur on the same edge, direct the write to the pre-swap shadow bank.
REQ-024 SHALL, in IDLE, toggle active_bank on the edge where swap_req or swap_pending is 1, and clear swap_pending.
REQ-025 SHALL, for swap_req received in RUN or DONE, set swap_pending and leave the running sequence on the old bank; the swap SHALL apply on the first IDLE edge.
REQ-026 SHALL, when start and a swap coincide in IDLE, make the new sequence read the newly active bank.

Reset
REQ-027 SHALL, on reset assertion, immediately force state IDLE, active_bank=0, swap_pending=0, and all outputs to 0, regardless of the clock.
REQ-028 SHALL, on reset, initialise both banks so that entry i = (NUM_TAPS - i) mod 2^COEFF_WIDTH, discarding previously written values.
REQ-029 SHALL abandon any sequence in progress when reset is applied, with no done pulse.

Structure
REQ-030 SHALL take the FSM state enumeration and the COEFF_WIDTH and NUM_TAPS defaults from shared package fir_pkg.
REQ-031 SHALL implement each bank as sub-module coeff_bank_mem, instantiated twice, each with a synchronous write, an asynchronous read and reset initialisation.

Verification
REQ-032 SHALL verify: reset, then start with reverse=0 and en=1 -> coeff_out 8,7,6,5,4,3,2,1 on cycles 1-8; coeff_last on value 1; done on cycle 9.
REQ-033 SHALL verify: start with reverse=1 -> coeff_out 1..8 with coeff_addr 7..0, and coeff_last on value 8.
REQ-034 SHALL verify: write 0x10..0x17 to addresses 0-7, swap_req in IDLE, then start -> active_bank=1 and output 0x10..0x17; a write to address 9 has no effect.
REQ-035 SHALL verify: swap_req on the third coefficient of a run -> the run completes 8..1, swap_pending=1 until the first IDLE edge, then active_bank toggles.
REQ-036 SHALL verify: en low for 2 cycles after the 4th coefficient -> 2 cycles with coeff_valid=0 and coeff_out=0, then 4,3,2,1 resume, for 8 valid coefficients total.
REQ-037 SHALL verify: reset asserted mid-run at the 5th coefficient -> outputs 0 within the same cycle, busy=0, no done pulse, and the next run outputs the default 8..1.
